// File: rtl/multi_cycle_control.sv
// State register and control-signal generator for the multicycle CPU.
// Registers the next-state code, decodes control, latches halt and counts fetches.
module multi_cycle_control #(
    parameter int COUNT_W = 16
) (
    input  logic               CLK,
    input  logic               Reset,
    input  logic [2:0]         next_state,
    input  logic [5:0]         opcode,
    input  logic               zero,
    output logic [2:0]         state,
    output logic               PCWre,
    output logic               IRWre,
    output logic               RegWre,
    output logic               mRD,
    output logic               mWR,
    output logic               ALUSrcA,
    output logic               ALUSrcB,
    output logic [1:0]         RegDst,
    output logic               WrRegDSrc,
    output logic               DBDataSrc,
    output logic               ExtSel,
    output logic [1:0]         PCSrc,
    output logic [2:0]         ALUOp,
    output logic               halted,
    output logic [COUNT_W-1:0] inst_count
);

    typedef enum logic [2:0] {
        S_IF   = 3'b000,
        S_ID   = 3'b001,
        S_CEXE = 3'b010,
        S_MEM  = 3'b011,
        S_CWB  = 3'b100,
        S_BEXE = 3'b101,
        S_AEXE = 3'b110,
        S_AWB  = 3'b111
    } state_t;

    localparam logic [5:0] OP_ADD   = 6'b000000;
    localparam logic [5:0] OP_SUB   = 6'b000001;
    localparam logic [5:0] OP_ADDIU = 6'b000010;
    localparam logic [5:0] OP_AND   = 6'b010000;
    localparam logic [5:0] OP_ANDI  = 6'b010001;
    localparam logic [5:0] OP_ORI   = 6'b010010;
    localparam logic [5:0] OP_SLL   = 6'b011000;
    localparam logic [5:0] OP_SLT   = 6'b100110;
    localparam logic [5:0] OP_SLTI  = 6'b100111;
    localparam logic [5:0] OP_SW    = 6'b110000;
    localparam logic [5:0] OP_LW    = 6'b110001;
    localparam logic [5:0] OP_BEQ   = 6'b110100;
    localparam logic [5:0] OP_J     = 6'b111000;
    localparam logic [5:0] OP_JR    = 6'b111001;
    localparam logic [5:0] OP_JAL   = 6'b111010;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    localparam logic [COUNT_W-1:0] COUNT_ONE = {{(COUNT_W-1){1'b0}}, 1'b1};

    state_t cur_state;
    state_t nxt_state;
    logic   legal_op;
    logic   aWB_writes;

    assign nxt_state = state_t'(next_state);
    assign state     = cur_state;

    // Once halted the machine parks in IF and neither fetches nor counts until reset.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            cur_state  <= S_IF;
            halted     <= 1'b0;
            inst_count <= '0;
        end else if (halted) begin
            cur_state <= S_IF;
        end else begin
            cur_state <= nxt_state;
            if (cur_state == S_ID && opcode == OP_HALT)
                halted <= 1'b1;
            if (cur_state == S_IF && inst_count != '1)
                inst_count <= inst_count + COUNT_ONE;
        end
    end

    // Unknown opcodes decode as add but must never write anything.
    always_comb begin
        legal_op = 1'b0;
        case (opcode)
            OP_ADD, OP_SUB, OP_ADDIU, OP_AND, OP_ANDI, OP_ORI, OP_SLL, OP_SLT,
            OP_SLTI, OP_SW, OP_LW, OP_BEQ, OP_J, OP_JR, OP_JAL, OP_HALT:
                legal_op = 1'b1;
            default: legal_op = 1'b0;
        endcase
    end

    assign aWB_writes = legal_op && !(opcode == OP_HALT || opcode == OP_J ||
                                      opcode == OP_JR || opcode == OP_SW ||
                                      opcode == OP_BEQ);

    // Write enables are qualified by Reset so an abort takes effect without a clock edge.
    always_comb begin
        IRWre  = 1'b0;
        PCWre  = 1'b0;
        RegWre = 1'b0;
        mRD    = 1'b0;
        mWR    = 1'b0;
        if (Reset && !halted) begin
            IRWre = (cur_state == S_IF);
            PCWre = (cur_state != S_IF) && (nxt_state == S_IF) &&
                    !(cur_state == S_ID && opcode == OP_HALT);
        end
        if (Reset) begin
            RegWre = (cur_state == S_AWB && aWB_writes) ||
                     (cur_state == S_CWB && opcode == OP_LW) ||
                     (cur_state == S_ID  && opcode == OP_JAL);
            mRD    = (cur_state == S_MEM) && (opcode == OP_LW);
            mWR    = (cur_state == S_MEM) && (opcode == OP_SW);
        end
    end

    always_comb begin
        ALUSrcA   = (opcode == OP_SLL);
        ALUSrcB   = 1'b0;
        RegDst    = 2'b10;
        WrRegDSrc = (opcode != OP_JAL);
        DBDataSrc = (opcode == OP_LW);
        ExtSel    = !(opcode == OP_ANDI || opcode == OP_ORI);
        PCSrc     = 2'b00;
        ALUOp     = 3'b000;
        case (opcode)
            OP_ADDIU, OP_ANDI, OP_ORI, OP_SLTI, OP_LW: begin
                ALUSrcB = 1'b1;
                RegDst  = 2'b01;
            end
            OP_SW:   ALUSrcB = 1'b1;
            OP_JAL:  RegDst  = 2'b00;
            default: ;
        endcase
        case (opcode)
            OP_J, OP_JAL: PCSrc = 2'b11;
            OP_JR:        PCSrc = 2'b10;
            OP_BEQ:       PCSrc = zero ? 2'b01 : 2'b00;
            default:      PCSrc = 2'b00;
        endcase
        case (opcode)
            OP_SUB, OP_BEQ:   ALUOp = 3'b001;
            OP_SLL:           ALUOp = 3'b010;
            OP_ORI:           ALUOp = 3'b011;
            OP_AND, OP_ANDI:  ALUOp = 3'b100;
            OP_SLT, OP_SLTI:  ALUOp = 3'b110;
            default:          ALUOp = 3'b000;
        endcase
    end

endmodule

// File: tb/tb_multi_cycle_control.sv
// Self-checking bench for multi_cycle_control: directed instruction runs plus
// random instruction streams compared against a per-instruction reference model.
module tb_multi_cycle_control;

    localparam logic [2:0] S_IF = 3'd0, S_ID = 3'd1, S_CEXE = 3'd2, S_MEM = 3'd3;
    localparam logic [2:0] S_CWB = 3'd4, S_BEXE = 3'd5, S_AEXE = 3'd6, S_AWB = 3'd7;

    localparam logic [5:0] ADD = 6'b000000, SUB = 6'b000001, ADDIU = 6'b000010;
    localparam logic [5:0] AND_ = 6'b010000, ANDI = 6'b010001, ORI = 6'b010010;
    localparam logic [5:0] SLL = 6'b011000, SLT = 6'b100110, SLTI = 6'b100111;
    localparam logic [5:0] SW = 6'b110000, LW = 6'b110001, BEQ = 6'b110100;
    localparam logic [5:0] J = 6'b111000, JR = 6'b111001, JAL = 6'b111010;
    localparam logic [5:0] HALT = 6'b111111, ILLEGAL = 6'b101010;

    logic        CLK = 1'b0;
    logic        Reset;
    logic [2:0]  next_state;
    logic [5:0]  opcode;
    logic        zero;
    logic [2:0]  state, state_2;
    logic        PCWre, IRWre, RegWre, mRD, mWR, ALUSrcA, ALUSrcB;
    logic        PCWre_2, IRWre_2, RegWre_2, mRD_2, mWR_2, ALUSrcA_2, ALUSrcB_2;
    logic [1:0]  RegDst, PCSrc, RegDst_2, PCSrc_2;
    logic        WrRegDSrc, DBDataSrc, ExtSel, halted;
    logic        WrRegDSrc_2, DBDataSrc_2, ExtSel_2, halted_2;
    logic [2:0]  ALUOp, ALUOp_2;
    logic [15:0] inst_count;
    logic [1:0]  inst_count_2;

    int errors = 0;
    int checks = 0;

    logic [2:0] m_state;
    logic       m_halted;
    int         m_count;

    always #5 CLK = ~CLK;

    multi_cycle_control #(.COUNT_W(16)) dut (
        .CLK(CLK), .Reset(Reset), .next_state(next_state), .opcode(opcode), .zero(zero),
        .state(state), .PCWre(PCWre), .IRWre(IRWre), .RegWre(RegWre), .mRD(mRD), .mWR(mWR),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .RegDst(RegDst), .WrRegDSrc(WrRegDSrc),
        .DBDataSrc(DBDataSrc), .ExtSel(ExtSel), .PCSrc(PCSrc), .ALUOp(ALUOp),
        .halted(halted), .inst_count(inst_count)
    );

    multi_cycle_control #(.COUNT_W(2)) dut_narrow (
        .CLK(CLK), .Reset(Reset), .next_state(next_state), .opcode(opcode), .zero(zero),
        .state(state_2), .PCWre(PCWre_2), .IRWre(IRWre_2), .RegWre(RegWre_2), .mRD(mRD_2),
        .mWR(mWR_2), .ALUSrcA(ALUSrcA_2), .ALUSrcB(ALUSrcB_2), .RegDst(RegDst_2),
        .WrRegDSrc(WrRegDSrc_2), .DBDataSrc(DBDataSrc_2), .ExtSel(ExtSel_2), .PCSrc(PCSrc_2),
        .ALUOp(ALUOp_2), .halted(halted_2), .inst_count(inst_count_2)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic isLegal(input logic [5:0] op);
        return op inside {ADD, SUB, ADDIU, AND_, ANDI, ORI, SLL, SLT, SLTI,
                          SW, LW, BEQ, J, JR, JAL, HALT};
    endfunction

    // Expected controls are derived from the instruction-level rules, not from any encoding.
    task automatic checkOutput();
        logic [5:0] op;
        logic       en, eIr, ePc, eRw;
        logic [1:0] eDst, eSrc;
        logic [2:0] eAlu;
        op  = opcode;
        en  = Reset;
        eIr = en && m_state == S_IF && !m_halted;
        ePc = en && !m_halted && m_state != S_IF && next_state == S_IF &&
              !(m_state == S_ID && op == HALT);
        eRw = en && ((m_state == S_AWB && isLegal(op) && !(op inside {HALT, J, JR, SW, BEQ})) ||
                     (m_state == S_CWB && op == LW) || (m_state == S_ID && op == JAL));
        eDst = (op == JAL) ? 2'd0 : (op inside {ADDIU, ANDI, ORI, SLTI, LW}) ? 2'd1 : 2'd2;
        eSrc = (op inside {J, JAL}) ? 2'd3 : (op == JR) ? 2'd2 : (op == BEQ && zero) ? 2'd1 : 2'd0;
        case (op)
            SUB, BEQ:   eAlu = 3'd1;
            SLL:        eAlu = 3'd2;
            ORI:        eAlu = 3'd3;
            AND_, ANDI: eAlu = 3'd4;
            SLT, SLTI:  eAlu = 3'd6;
            default:    eAlu = 3'd0;
        endcase
        chk("state", 16'(state), 16'(m_state));
        chk("halted", 16'(halted), 16'(m_halted));
        chk("inst_count", inst_count, 16'(m_count));
        chk("inst_count_w2", 16'(inst_count_2), 16'((m_count > 3) ? 3 : m_count));
        chk("IRWre", 16'(IRWre), 16'(eIr));
        chk("PCWre", 16'(PCWre), 16'(ePc));
        chk("RegWre", 16'(RegWre), 16'(eRw));
        chk("mRD", 16'(mRD), 16'(en && m_state == S_MEM && op == LW));
        chk("mWR", 16'(mWR), 16'(en && m_state == S_MEM && op == SW));
        chk("ALUSrcA", 16'(ALUSrcA), 16'(op == SLL));
        chk("ALUSrcB", 16'(ALUSrcB), 16'(op inside {ADDIU, ANDI, ORI, SLTI, LW, SW}));
        chk("RegDst", 16'(RegDst), 16'(eDst));
        chk("WrRegDSrc", 16'(WrRegDSrc), 16'(op != JAL));
        chk("DBDataSrc", 16'(DBDataSrc), 16'(op == LW));
        chk("ExtSel", 16'(ExtSel), 16'(!(op inside {ANDI, ORI})));
        chk("PCSrc", 16'(PCSrc), 16'(eSrc));
        chk("ALUOp", 16'(ALUOp), 16'(eAlu));
    endtask

    // One clock cycle: drive inputs, check combinational outputs, then advance the model.
    task automatic applyStimulus(input logic [2:0] ns, input logic [5:0] op, input logic z);
        logic nh;
        next_state = ns;
        opcode     = op;
        zero       = z;
        #1;
        checkOutput();
        @(posedge CLK);
        if (Reset) begin
            nh = m_halted;
            if (!m_halted) begin
                if (m_state == S_IF && m_count < 65535) m_count++;
                if (m_state == S_ID && op == HALT) nh = 1'b1;
                m_state = ns;
            end else begin
                m_state = S_IF;
            end
            m_halted = nh;
        end
        #1;
    endtask

    task automatic runInstr(input logic [5:0] op, input logic z, input logic rand_z);
        logic [2:0] seq[$];
        logic [2:0] ns;
        seq = {S_IF, S_ID};
        case (op)
            LW:               seq = {seq, S_CEXE, S_MEM, S_CWB};
            SW:               seq = {seq, S_CEXE, S_MEM};
            BEQ:              seq = {seq, S_BEXE};
            J, JR, JAL, HALT: ;
            default:          seq = {seq, S_AEXE, S_AWB};
        endcase
        for (int i = 0; i < seq.size(); i++) begin
            ns = (i + 1 < seq.size()) ? seq[i + 1] : S_IF;
            applyStimulus(ns, op, rand_z ? 1'($urandom_range(0, 1)) : z);
        end
    endtask

    task automatic modelReset();
        m_state  = S_IF;
        m_halted = 1'b0;
        m_count  = 0;
    endtask

    logic [5:0] pool [16];

    initial begin
        pool = '{ADD, SUB, ADDIU, AND_, ANDI, ORI, SLL, SLT, SLTI, SW, LW, BEQ,
                 J, JR, JAL, ILLEGAL};
        Reset      = 1'b0;
        next_state = S_IF;
        opcode     = ADD;
        zero       = 1'b0;
        modelReset();
        applyStimulus(S_ID, ADD, 1'b0);
        applyStimulus(S_ID, SW, 1'b0);
        Reset = 1'b1;

        runInstr(ADD, 1'b0, 1'b0);
        runInstr(LW, 1'b0, 1'b0);
        runInstr(BEQ, 1'b1, 1'b0);
        runInstr(BEQ, 1'b0, 1'b0);
        runInstr(ADD, 1'b0, 1'b0);
        chk("narrow_saturated", 16'(inst_count_2), 16'd3);

        for (int n = 0; n < 60; n++)
            runInstr(pool[$urandom_range(0, 15)], 1'b0, 1'b1);

        // Abort a store while it sits in MEM: mWR must drop with no clock edge.
        applyStimulus(S_ID, SW, 1'b0);
        applyStimulus(S_CEXE, SW, 1'b0);
        applyStimulus(S_MEM, SW, 1'b0);
        next_state = S_IF;
        #1;
        chk("mWR_before_abort", 16'(mWR), 16'd1);
        Reset = 1'b0;
        #1;
        modelReset();
        chk("mWR_after_abort", 16'(mWR), 16'd0);
        chk("state_after_abort", 16'(state), 16'(S_IF));
        chk("count_after_abort", inst_count, 16'd0);
        checkOutput();
        @(posedge CLK);
        #1;
        Reset = 1'b1;

        runInstr(JAL, 1'b0, 1'b0);
        runInstr(HALT, 1'b0, 1'b0);
        chk("halted_set", 16'(halted), 16'd1);
        for (int n = 0; n < 12; n++)
            applyStimulus(3'($urandom_range(0, 7)), pool[$urandom_range(0, 15)],
                          1'($urandom_range(0, 1)));
        chk("count_frozen", inst_count, 16'd2);
        chk("state_parked", 16'(state), 16'(S_IF));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multi_cycle_control.md
Name: multi_cycle_control

Overview:
State register and control-signal generator for the multicycle CPU. It registers the 3-bit state produced by the next-state logic each cycle. From the current state and opcode it drives every datapath enable and mux select. It also latches halt and counts fetched instructions. It sits directly downstream of the next-state block and upstream of the datapath (PC, IR, register file, ALU, data memory).

Parameters:
COUNT_W, 16, width of the instruction-fetch counter (saturating)

Ports:
CLK  in  1  clock, rising edge
Reset  in  1  asynchronous, active-low reset
next_state  in  3  state from next-state logic
opcode  in  6  IR[31:26]
zero  in  1  ALU zero flag
state  out  3  current registered state
PCWre  out  1  PC write enable
IRWre  out  1  IR write enable
RegWre  out  1  register file write enable
mRD  out  1  data memory read
mWR  out  1  data memory write
ALUSrcA  out  1  1 = shamt, 0 = rs
ALUSrcB  out  1  1 = extended immediate, 0 = rt
RegDst  out  2  00 = $31, 01 = rt, 10 = rd
WrRegDSrc  out  1  0 = PC+4, 1 = DB bus
DBDataSrc  out  1  1 = memory data, 0 = ALU result
ExtSel  out  1  1 = sign extend, 0 = zero extend
PCSrc  out  2  00 = PC+4, 01 = branch target, 10 = rs (jr), 11 = jump target
ALUOp  out  3  000 add, 001 sub, 010 sll, 011 or, 100 and, 110 slt
halted  out  1  sticky halt flag
inst_count  out  COUNT_W  number of IF->ID transitions

Behaviour:
- Decided: one clock CLK; Reset is asynchronous, active-low.
- State encoding: IF=000, ID=001, cEXE=010, MEM=011, cWB=100, bEXE=101, aEXE=110, aWB=111.
- Opcodes: add 000000, sub 000001, addiu 000010, and 010000, andi 010001, ori 010010, sll 011000, slt 100110, slti 100111, sw 110000, lw 110001, beq 110100, j 111000, jr 111001, jal 111010, halt 111111. Any other opcode decodes as add with no writes.
- Reset (Reset=0, asynchronous): state=IF, halted=0, inst_count=0. While Reset=0, PCWre, IRWre, RegWre, mRD and mWR are all forced to 0. The first IF is the cycle after Reset deasserts.
- Rising edge CLK with halted=0: state <= next_state.
- Rising edge CLK with halted=1: state is held at IF.
- halted: set on the edge where state=ID and opcode=halt. It stays set until reset.
- inst_count: increments on each edge where state=IF and halted=0. It saturates at all-ones and does not wrap.
- All control outputs are combinational from state, opcode, zero and halted.
- IRWre = 1 iff state=IF and halted=0.
- PCWre = 1 iff halted=0, state≠IF and next_state=IF. It is 0 in ID for halt. Each instruction makes exactly one PC update, in its final cycle.
- RegWre = 1 in aWB for every opcode except halt, j, jr, sw and beq. It is also 1 in cWB (lw) and in ID for jal. It is 0 otherwise.
- mRD = 1 iff state=MEM and opcode=lw. mWR = 1 iff state=MEM and opcode=sw.
- ALUSrcA = 1 iff opcode=sll.
- ALUSrcB = 1 for addiu, andi, ori, slti, lw and sw.
- RegDst: 00 for jal, 01 for addiu/andi/ori/slti/lw, 10 otherwise.
- WrRegDSrc = 0 only for jal. DBDataSrc = 1 only for lw.
- ExtSel = 0 for andi and ori, 1 otherwise.
- PCSrc: 11 for j and jal; 10 for jr; 01 for beq only when zero=1; 00 otherwise. PCSrc is valid in the cycle where PCWre=1.
- ALUOp: add/addiu/lw/sw → 000; sub/beq → 001; sll → 010; ori → 011; and/andi → 100; slt/slti → 110.
- Illegal next_state values cannot occur, since all 8 codes are valid states.
- Reset asserted mid-instruction aborts that instruction immediately; no partial write completes after the Reset falling edge.

Test Plan:
- Reset=0 for 2 cycles, then release with opcode=add → state sequence 000,001,110,111,000. RegWre=1 only in 111. PCWre=1 only in 111. RegDst=10 and ALUOp=000 throughout.
- lw (110001) → states 000,001,010,011,100. mRD=1 in 011. RegWre=1 and DBDataSrc=1 in 100. ALUSrcB=1, RegDst=01. PCWre=1 only in 100.
- beq (110100), run twice with zero=1 and zero=0 → states 000,001,101. In state 101, PCSrc=01 with zero=1 and PCSrc=00 with zero=0. ALUOp=001 and PCWre=1 in both runs. RegWre stays 0.
- jal (111010) → states 000,001. In ID: RegWre=1, RegDst=00, WrRegDSrc=0, PCSrc=11, PCWre=1. Then halt (111111) → halted=1 after the ID edge, and state stays at 000 for ≥10 cycles. PCWre and IRWre stay 0, and inst_count is frozen at 2.
- Assert Reset asynchronously mid-cycle while state=MEM with sw → mWR drops to 0 immediately, with no clock edge. state becomes 000 and inst_count becomes 0.
- COUNT_W=2, run 5 add instructions → inst_count reads 1,2,3,3,3 and does not wrap.
